handshaked_reg_chain: RTL and testbench



---
 rtl/handshaked_reg_chain.sv | 121 ++++++++++++
 tb/tb_handshaked_reg_chain.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/handshaked_reg_chain.sv
// ============================================================================
//  Module   : handshaked_reg_chain
//  Purpose  : Chain of DEPTH valid/ready register stages. Adds DEPTH cycles of
//             registered latency to a handshaked stream with full throughput,
//             backpressure, bubble collapsing, flush and occupancy reporting.
//  Config   : `define HANDSHAKED_REG_CHAIN_DATA_RST_EN to make rst also load
//             INIT_VAL into every data register. When undefined, only the
//             valid bits and the occupancy counter are reset.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             i_din_data/_vld    - upstream payload and valid
//             o_din_rd           - upstream ready
//             o_dout_data/_vld   - downstream payload and valid (last stage)
//             i_dout_rd          - downstream ready
//             i_flush            - synchronous clear of all stages
//             o_occupancy        - number of stages holding valid data
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module handshaked_reg_chain #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        i_din_data,
  input  logic                         i_din_vld,
  output logic                         o_din_rd,
  output logic [DATA_WIDTH-1:0]        o_dout_data,
  output logic                         o_dout_vld,
  input  logic                         i_dout_rd,
  input  logic                         i_flush,
  output logic [$clog2(DEPTH+1)-1:0]   o_occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  // w_rd[i] is the ready seen by stage i; w_rd[DEPTH] is the sink's ready.
  // A stage is ready when it is empty or its content moves on this cycle,
  // which is what lets an empty stage absorb words while the output stalls.
  logic [DEPTH:0]      w_rd;
  logic [DEPTH-1:0]    w_vld;
  logic                w_in_xfer;
  logic                w_out_xfer;
  logic [OCC_W-1:0]    r_occ;

  assign w_rd[DEPTH] = i_dout_rd;
  assign o_din_rd    = w_rd[0] & ~i_flush & ~rst;
  assign w_in_xfer   = i_din_vld & o_din_rd;
  assign w_out_xfer  = w_vld[DEPTH-1] & i_dout_rd;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic                  r_vld;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_up_vld;
    logic [DATA_WIDTH-1:0] w_up_data;

    assign w_rd[i]  = ~r_vld | w_rd[i+1];
    assign w_vld[i] = r_vld;

    if (i == 0) begin : g_head
      // Only a completed input handshake may create a valid word.
      assign w_up_vld  = w_in_xfer;
      assign w_up_data = i_din_data;
    end else begin : g_body
      assign w_up_vld  = g_stage[i-1].r_vld;
      assign w_up_data = g_stage[i-1].r_data;
    end

    always_ff @(posedge clk) begin
      if (rst || i_flush) begin
        r_vld <= 1'b0;
      end else if (w_rd[i]) begin
        r_vld <= w_up_vld;
      end
    end

`ifdef HANDSHAKED_REG_CHAIN_DATA_RST_EN
    always_ff @(posedge clk) begin
      if (rst) begin
        r_data <= INIT_VAL;
      end else if (w_rd[i]) begin
        r_data <= w_up_data;
      end
    end
`else
    // Payload is don't-care while its valid bit is low, so no reset here.
    always_ff @(posedge clk) begin
      if (w_rd[i]) begin
        r_data <= w_up_data;
      end
    end
`endif
  end

`ifndef HANDSHAKED_REG_CHAIN_DATA_RST_EN
  // INIT_VAL only matters for the data-reset build.
  logic w_unused_init;
  assign w_unused_init = ^INIT_VAL;
`endif

  assign o_dout_vld  = g_stage[DEPTH-1].r_vld;
  assign o_dout_data = g_stage[DEPTH-1].r_data;

  // Occupancy tracks handshakes directly; simultaneous in/out cancel out.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_occ <= '0;
    end else if (w_in_xfer && !w_out_xfer) begin
      r_occ <= r_occ + 1'b1;
    end else if (!w_in_xfer && w_out_xfer) begin
      r_occ <= r_occ - 1'b1;
    end
  end

  assign o_occupancy = r_occ;

endmodule

`default_nettype wire

// File: tb/tb_handshaked_reg_chain.sv
// ============================================================================
//  Module   : tb_handshaked_reg_chain
//  Purpose  : Self-checking bench for handshaked_reg_chain. A DEPTH=3 instance
//             runs a table of directed vectors (streaming, fill under
//             backpressure, bubble collapse, flush) plus hand-written reset
//             sequences; DEPTH=1 and DEPTH=16 instances run a random-stall
//             stream against a queue scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_handshaked_reg_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // DEPTH=3, 8-bit instance
  logic [7:0]  d3_in, d3_out;
  logic        d3_vld, d3_in_rd, d3_out_vld, d3_rdy, d3_flush;
  logic [1:0]  d3_occ;
  // DEPTH=1, 16-bit instance
  logic [15:0] a_in, a_out;
  logic        a_vld, a_in_rd, a_out_vld, a_rdy, a_flush;
  logic [0:0]  a_occ;
  // DEPTH=16, 16-bit instance
  logic [15:0] b_in, b_out;
  logic        b_vld, b_in_rd, b_out_vld, b_rdy, b_flush;
  logic [4:0]  b_occ;

  handshaked_reg_chain #(.DATA_WIDTH(8), .DEPTH(3), .INIT_VAL(8'h5A)) u_dut3 (
    .clk(clk), .rst(rst),
    .i_din_data(d3_in), .i_din_vld(d3_vld), .o_din_rd(d3_in_rd),
    .o_dout_data(d3_out), .o_dout_vld(d3_out_vld), .i_dout_rd(d3_rdy),
    .i_flush(d3_flush), .o_occupancy(d3_occ)
  );

  handshaked_reg_chain #(.DATA_WIDTH(16), .DEPTH(1), .INIT_VAL(16'h0)) u_dut1 (
    .clk(clk), .rst(rst),
    .i_din_data(a_in), .i_din_vld(a_vld), .o_din_rd(a_in_rd),
    .o_dout_data(a_out), .o_dout_vld(a_out_vld), .i_dout_rd(a_rdy),
    .i_flush(a_flush), .o_occupancy(a_occ)
  );

  handshaked_reg_chain #(.DATA_WIDTH(16), .DEPTH(16), .INIT_VAL(16'h0)) u_dut16 (
    .clk(clk), .rst(rst),
    .i_din_data(b_in), .i_din_vld(b_vld), .o_din_rd(b_in_rd),
    .o_dout_data(b_out), .o_dout_vld(b_out_vld), .i_dout_rd(b_rdy),
    .i_flush(b_flush), .o_occupancy(b_occ)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       flush;
    logic       vld;
    logic [7:0] data;
    logic       rdy;
    logic       e_in_rd;
    logic       e_out_vld;
    logic [7:0] e_data;
    logic [1:0] e_occ;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic fl, input logic v, input logic [7:0] d,
                              input logic r, input logic eir, input logic eov,
                              input logic [7:0] ed, input logic [1:0] eo);
    vec_t x;
    x.flush = fl; x.vld = v; x.data = d; x.rdy = r;
    x.e_in_rd = eir; x.e_out_vld = eov; x.e_data = ed; x.e_occ = eo;
    tbl.push_back(x);
  endfunction

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  task automatic fuzz_cycle(input bit drain);
    logic [15:0] ea, eb;
    @(negedge clk);
    a_vld = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
    a_in  = 16'($urandom);
    a_rdy = drain ? 1'b1 : 1'($urandom_range(0, 1));
    b_vld = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
    b_in  = 16'($urandom);
    b_rdy = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
    #1;
    if (a_vld && a_in_rd) qa.push_back(a_in);
    if (b_vld && b_in_rd) qb.push_back(b_in);
    if (a_out_vld && a_rdy) begin
      check("fuzz1 word pending", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        check("fuzz1 data", a_out, ea);
      end
    end
    if (b_out_vld && b_rdy) begin
      check("fuzz16 word pending", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        check("fuzz16 data", b_out, eb);
      end
    end
    @(posedge clk);
    #1;
    check("fuzz1 occupancy", a_occ, qa.size());
    check("fuzz16 occupancy", b_occ, qb.size());
  endtask

  initial begin
    rst = 1'b1;
    d3_in = '0; d3_vld = 1'b0; d3_rdy = 1'b0; d3_flush = 1'b0;
    a_in = '0; a_vld = 1'b0; a_rdy = 1'b0; a_flush = 1'b0;
    b_in = '0; b_vld = 1'b0; b_rdy = 1'b0; b_flush = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1;
    check("rst din_rd low", d3_in_rd, 1'b0);
    @(posedge clk); #1;
    check("rst dout_vld", d3_out_vld, 1'b0);
    check("rst occupancy", d3_occ, 2'd0);
`ifdef HANDSHAKED_REG_CHAIN_DATA_RST_EN
    check("rst dout_data init", d3_out, 8'h5A);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post-rst din_rd", d3_in_rd, 1'b1);

    // ---------------- vector table (DEPTH=3) ----------------
    // Streaming 0x01..0x0A with dout_rd=1, then three idle cycles to drain.
    // Word k enters stage 0 at edge k and is at the output after edge k+2.
    for (int t = 0; t < 13; t++) begin
      add(1'b0, (t < 10), (t < 10) ? 8'(t + 1) : 8'h00, 1'b1,
          1'b1, (t >= 2 && t <= 11), 8'(t - 1),
          (t < 3) ? 2'(t + 1) : ((t <= 9) ? 2'd3 : 2'(12 - t)));
    end
    // Fill under backpressure, full + ready, then drain.
    add(1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
    add(1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2);
    add(1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 8'hA0, 2'd3);
    add(1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 8'hA0, 2'd3);
    add(1'b0, 1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 8'hA1, 2'd3);
    add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 8'hA2, 2'd2);
    add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b1, 8'hA3, 2'd1);
    add(1'b0, 1'b0, 8'hEE, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    // Bubble collapse: one word, two idle, one word, all stalled.
    add(1'b0, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB0, 2'd1);
    add(1'b0, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 8'hB0, 2'd2);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB0, 2'd2);
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hB0, 2'd2);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hB1, 2'd1);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    // Flush while full with a word offered; that word must never appear.
    add(1'b0, 1'b1, 8'hC0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd1);
    add(1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd2);
    add(1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 8'hC0, 2'd3);
    add(1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);
    add(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0);

    foreach (tbl[k]) begin
      @(negedge clk);
      d3_flush = tbl[k].flush;
      d3_vld   = tbl[k].vld;
      d3_in    = tbl[k].data;
      d3_rdy   = tbl[k].rdy;
      #1;
      check($sformatf("vec%0d din_rd", k), d3_in_rd, tbl[k].e_in_rd);
      @(posedge clk); #1;
      check($sformatf("vec%0d dout_vld", k), d3_out_vld, tbl[k].e_out_vld);
      check($sformatf("vec%0d occupancy", k), d3_occ, tbl[k].e_occ);
      if (tbl[k].e_out_vld) check($sformatf("vec%0d dout_data", k), d3_out, tbl[k].e_data);
    end

    // ---------------- reset mid-stream ----------------
    @(negedge clk); d3_flush = 1'b0; d3_rdy = 1'b0; d3_vld = 1'b1; d3_in = 8'hD0;
    @(negedge clk); d3_in = 8'hD1;
    @(negedge clk); d3_vld = 1'b0;
    @(posedge clk); #1;
    check("midrst pre dout_vld", d3_out_vld, 1'b1);
    check("midrst pre dout_data", d3_out, 8'hD0);
    check("midrst pre occupancy", d3_occ, 2'd2);
    @(negedge clk); rst = 1'b1; d3_vld = 1'b1; d3_in = 8'hD2;
    #1;
    check("midrst din_rd", d3_in_rd, 1'b0);
    @(posedge clk); #1;
    check("midrst dout_vld", d3_out_vld, 1'b0);
    check("midrst occupancy", d3_occ, 2'd0);
`ifdef HANDSHAKED_REG_CHAIN_DATA_RST_EN
    check("midrst dout_data init", d3_out, 8'h5A);
`endif
    @(negedge clk); rst = 1'b0; d3_vld = 1'b0; d3_rdy = 1'b1;
    #1;
    check("midrst release din_rd", d3_in_rd, 1'b1);
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check($sformatf("midrst after%0d dout_vld", n), d3_out_vld, 1'b0);
      check($sformatf("midrst after%0d occupancy", n), d3_occ, 2'd0);
    end

    // ---------------- random stall stream, DEPTH=1 and DEPTH=16 ----------------
    for (int c = 0; c < 10000; c++) fuzz_cycle(1'b0);
    for (int c = 0; c < 40; c++) fuzz_cycle(1'b1);
    check("fuzz1 drained", qa.size(), 32'd0);
    check("fuzz16 drained", qb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
